// File: rtl/regfile_banked.sv
// regfile_banked: NUM_BANKS x REGS_PER_BANK x XLEN register file; bank 0 = integer (x0 reads 0), bank 1 = FP. Optional: REGFILE_SCOREBOARD_EN.
// Latency: reads are combinational with same-cycle write bypass; writes and reserves land on the next posedge; post-reset clear takes REGS_PER_BANK cycles.
// Backpressure: ready is low during the clear; writes/reserves are dropped and all read outputs are 0 until ready rises.
module regfile_banked #(
  parameter int XLEN          = 64,
  parameter int REGS_PER_BANK = 32,
  parameter int NUM_BANKS     = 2,
  parameter int NUM_READ      = 2,
  localparam int AW = $clog2(REGS_PER_BANK),
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_READ*BW-1:0]   rd_bank,
  input  logic [NUM_READ*AW-1:0]   rd_addr,
  output logic [NUM_READ*XLEN-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [BW-1:0]            wr_bank,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                     rsv_en,
  input  logic [BW-1:0]            rsv_bank,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NUM_READ-1:0]      rd_pending,
`endif
  output logic                     ready
);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            wr_ok;
  logic [XLEN-1:0] mem_q [NUM_BANKS][REGS_PER_BANK];

  // Bank select beyond the populated banks addresses nothing.
  function automatic logic bank_ok(input logic [BW-1:0] b);
    return int'(b) < NUM_BANKS;
  endfunction

  // Bank-0 entry 0 is the hardwired-zero integer register.
  function automatic logic is_x0(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return (b == '0) && (a == '0);
  endfunction

  // A write only takes effect once cleared, to a real bank, and never to x0.
  assign wr_ok = (state_q == ST_READY) && wr_en && bank_ok(wr_bank) && !is_x0(wr_bank, wr_addr);
  assign ready = ready_q;

  // Clear sequencer: walk the index once, then stay ready until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(REGS_PER_BANK - 1)) begin
        state_d = ST_READY;
        ready_d = 1'b1;
      end
    end
  end

  // FSM, clear counter and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage: the clear zeroes one index in every bank per cycle; otherwise the single write port.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem_q[b][cnt_q] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_bank][wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  localparam int NE = NUM_BANKS * REGS_PER_BANK;

  logic [NE-1:0] pend_q, pend_d;
  logic          rsv_ok;

  function automatic int eidx(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return int'(b) * REGS_PER_BANK + int'(a);
  endfunction

  assign rsv_ok = (state_q == ST_READY) && rsv_en && bank_ok(rsv_bank) && !is_x0(rsv_bank, rsv_addr);

  // Pending bits: wiped during clear; a write retires, a same-cycle reserve re-arms (reserve wins).
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_CLEAR) begin
      pend_d = '0;
    end else begin
      if (wr_ok) pend_d[eidx(wr_bank, wr_addr)] = 1'b0;
      if (rsv_ok) pend_d[eidx(rsv_bank, rsv_addr)] = 1'b1;
    end
  end

  // Pending bits have no reset of their own; the clear state initialises them.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end
`else
  // Without the scoreboard there is no per-entry pending state.
`endif

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [BW-1:0]   rb;
    logic [AW-1:0]   ra;
    logic            hit;
    logic [XLEN-1:0] rdat;

    assign rb  = rd_bank[i*BW +: BW];
    assign ra  = rd_addr[i*AW +: AW];
    assign hit = wr_en && (wr_bank == rb) && (wr_addr == ra);

    // Read mux: zero while clearing, for bad banks and x0; then bypass, then storage.
    always_comb begin
      rdat = '0;
      if (state_q == ST_READY && bank_ok(rb) && !is_x0(rb, ra)) begin
        if (hit) rdat = wr_data;
        else     rdat = mem_q[rb][ra];
      end
    end

    assign rd_data[i*XLEN +: XLEN] = rdat;

`ifdef REGFILE_SCOREBOARD_EN
    // A bypassed read already carries the new value, so it is not pending.
    assign rd_pending[i] = (state_q == ST_READY) && bank_ok(rb) && !is_x0(rb, ra) &&
                           pend_q[eidx(rb, ra)] && !hit;
`endif
  end

endmodule

// File: tb/tb_regfile_banked.sv
module tb_regfile_banked;
  localparam int XLEN = 64;
  localparam int RPB  = 32;
  localparam int NB   = 2;
  localparam int NR   = 2;
  localparam int AW   = 5;
  localparam int BW   = 1;

  logic                 clk;
  logic                 rst_n;
  logic [NR*BW-1:0]     rd_bank;
  logic [NR*AW-1:0]     rd_addr;
  logic [NR*XLEN-1:0]   rd_data;
  logic                 wr_en;
  logic [BW-1:0]        wr_bank;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 ready;
`ifdef REGFILE_SCOREBOARD_EN
  logic                 rsv_en;
  logic [BW-1:0]        rsv_bank;
  logic [AW-1:0]        rsv_addr;
  logic [NR-1:0]        rd_pending;
`endif

  regfile_banked #(.XLEN(XLEN), .REGS_PER_BANK(RPB), .NUM_BANKS(NB), .NUM_READ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef REGFILE_SCOREBOARD_EN
    .rsv_en(rsv_en), .rsv_bank(rsv_bank), .rsv_addr(rsv_addr), .rd_pending(rd_pending),
`endif
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural contents, cycles of clear remaining, pending flags.
  logic [XLEN-1:0] m_mem  [NB][RPB];
  bit              m_pend [NB][RPB];
  int              m_left;
  int              vec_cnt = 0;
  int              err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = RPB;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < RPB; a++) begin
        m_mem[b][a]  = '0;
        m_pend[b][a] = 1'b0;
      end
  endtask

  function automatic bit wr_hits(input int b, input int a);
    return wr_en && int'(wr_bank) == b && int'(wr_addr) == a;
  endfunction

  function automatic logic [63:0] exp_rd(input int p);
    int b;
    int a;
    b = int'(rd_bank[p*BW +: BW]);
    a = int'(rd_addr[p*AW +: AW]);
    if (m_left != 0 || b >= NB || (b == 0 && a == 0)) return '0;
    if (wr_hits(b, a)) return wr_data;
    return m_mem[b][a];
  endfunction

  function automatic bit exp_pend(input int p);
    int b;
    int a;
    b = int'(rd_bank[p*BW +: BW]);
    a = int'(rd_addr[p*AW +: AW]);
    if (m_left != 0 || b >= NB || (b == 0 && a == 0) || wr_hits(b, a)) return 1'b0;
    return m_pend[b][a];
  endfunction

  task automatic set_rd(input int p, input int b, input int a);
    rd_bank[p*BW +: BW] = BW'(b);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int b, input int a, input logic [63:0] d);
    wr_en = 1'b1; wr_bank = BW'(b); wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic idle();
    wr_en = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    rsv_en = 1'b0;
`endif
  endtask

  // Called before a posedge with inputs settled: compare outputs, clock, advance the model.
  task automatic step();
    int b;
    int a;
    #1;
    check("ready", ready, m_left == 0);
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rd_data%0d", p), rd_data[p*XLEN +: XLEN], exp_rd(p));
`ifdef REGFILE_SCOREBOARD_EN
      check($sformatf("rd_pending%0d", p), rd_pending[p], exp_pend(p));
`endif
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_left != 0) begin
      m_left--;
    end else begin
      b = int'(wr_bank);
      a = int'(wr_addr);
      if (wr_en && b < NB && !(b == 0 && a == 0)) begin
        m_mem[b][a]  = wr_data;
        m_pend[b][a] = 1'b0;
      end
`ifdef REGFILE_SCOREBOARD_EN
      b = int'(rsv_bank);
      a = int'(rsv_addr);
      if (rsv_en && b < NB && !(b == 0 && a == 0)) m_pend[b][a] = 1'b1;
`endif
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs(input int amax);
    for (int p = 0; p < NR; p++) set_rd(p, $urandom_range(0, NB-1), $urandom_range(0, amax));
    wr_en   = 1'($urandom_range(0, 1));
    wr_bank = BW'($urandom_range(0, NB-1));
    wr_addr = AW'($urandom_range(0, amax));
    wr_data = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) set_rd(0, int'(wr_bank), int'(wr_addr));
`ifdef REGFILE_SCOREBOARD_EN
    rsv_en   = 1'($urandom_range(0, 1));
    rsv_bank = BW'($urandom_range(0, NB-1));
    rsv_addr = AW'($urandom_range(0, amax));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rd_bank = '0; rd_addr = '0;
    wr_bank = '0; wr_addr = '0; wr_data = '0;
`ifdef REGFILE_SCOREBOARD_EN
    rsv_bank = '0; rsv_addr = '0;
`endif
    idle();
    model_reset();
    @(negedge clk);
    set_rd(0, 0, 7); set_rd(1, 1, 7);
    repeat (2) step();

    // Release reset; random traffic during clear must be ignored, including x5 = 0xFF.
    rst_n = 1'b1;
    for (int c = 0; c < RPB; c++) begin
      rand_inputs(31);
      if (c == 3) set_wr(0, 5, 64'hFF);
      step();
    end
    idle(); set_rd(0, 0, 5); set_rd(1, 0, 5); step();

    // x7 write then read on both ports; f7 untouched.
    set_wr(0, 7, 64'hDEADBEEF_00000001); step();
    idle(); set_rd(0, 0, 7); set_rd(1, 0, 7); step();
    set_rd(1, 1, 7); step();

    // x0 is hardwired zero; f0 is a normal register.
    set_wr(0, 0, 64'h1234); set_rd(0, 0, 0); step();
    idle(); step();
    set_wr(1, 0, 64'h1234); step();
    idle(); set_rd(0, 1, 0); step();

    // Bypass: f3 holds 0x55, write 0xAA while port 0 reads it.
    set_wr(1, 3, 64'h55); step();
    set_wr(1, 3, 64'hAA); set_rd(0, 1, 3); step();
    idle(); step();

`ifdef REGFILE_SCOREBOARD_EN
    // Reserve x4, reserve+write same cycle keeps it pending, lone write retires it.
    idle(); rsv_en = 1'b1; rsv_bank = 1'b0; rsv_addr = 5'd4; step();
    rsv_en = 1'b0; set_rd(0, 0, 4); step();
    rsv_en = 1'b1; set_wr(0, 4, 64'h44); step();
    idle(); step();
    set_wr(0, 4, 64'h45); step();
    idle(); step();
`endif

    for (int k = 0; k < 600; k++) begin
      rand_inputs(($urandom_range(0, 1) == 1) ? 3 : 31);
      step();
    end

    // Mid-operation reset restarts the full clear and wipes x9.
    idle(); set_wr(0, 9, 64'h77); step();
    idle(); set_rd(0, 0, 9); set_rd(1, 0, 9); step();
    rst_n = 1'b0;
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_rd0", rd_data[0 +: XLEN], 64'h0);
    #1;
    rst_n = 1'b1;
    model_reset();
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("clear_cycles", n, RPB);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
- Parametrised successor to the core's integer/FP register file: NUM_BANKS banks of REGS_PER_BANK entries, each XLEN bits wide.
- Bank 0 is the integer file and bank 1 the FP file. The bank is selected by an explicit port, not by opcode decode.
- Provides NUM_READ combinational read ports with write-to-read bypass, one synchronous write port, and hardwired-zero x0 in bank 0.
- After reset, a clear state machine zeroes every entry and holds ready low until the clear completes. Sits between decode and execute in the core pipeline.

Parameters:
- XLEN, 64, data width of each register.
- REGS_PER_BANK, 32, entries per bank; must be a power of 2 and at least 2.
- NUM_BANKS, 2, number of banks; bank 0 has x0 hardwired to zero.
- NUM_READ, 2, number of read ports.
- Derived: AW = clog2(REGS_PER_BANK); BW = max(1, clog2(NUM_BANKS)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_bank  in  NUM_READ*BW  bank select per read port; port i uses bits [i*BW +: BW].
- rd_addr  in  NUM_READ*AW  register index per read port.
- rd_data  out  NUM_READ*XLEN  read data per read port.
- wr_en  in  1  write strobe.
- wr_bank  in  BW  write bank select.
- wr_addr  in  AW  write register index.
- wr_data  in  XLEN  write data.
- ready  out  1  high once the clear sequence has completed.

Behaviour:
- States: CLEAR and READY. rst_n low asynchronously forces state=CLEAR, clear counter=0, ready=0.
- CLEAR:
  - On each posedge, entry[counter] is written to 0 in every bank, then counter increments.
  - On the posedge that clears index REGS_PER_BANK-1, state moves to READY. ready goes high after that edge.
  - The clear therefore takes exactly REGS_PER_BANK cycles after rst_n deasserts.
  - wr_en is ignored while in CLEAR: no write occurs and no error is flagged.
  - All rd_data outputs are forced to 0.
- READY:
  - Write: if wr_en=1, wr_bank<NUM_BANKS, and not (wr_bank==0 and wr_addr==0), then entry[wr_bank][wr_addr] <= wr_data on posedge. Otherwise no state changes.
  - Read: each port is combinational. Priority order:
    - rd_bank>=NUM_BANKS returns 0.
    - Bank 0, address 0 returns 0, even if a write to it is presented.
    - If wr_en=1 and (wr_bank,wr_addr) equals (rd_bank,rd_addr), the port returns wr_data (same-cycle bypass).
    - Otherwise the port returns the stored entry.
  - All read ports are independent; any number of them may address the same entry.
- Bank-1 entry 0 is an ordinary writable register.
- rst_n asserted mid-operation, whether in CLEAR or READY, restarts the full clear. Stored contents become 0 only as the clear proceeds, but reads return 0 throughout CLEAR, so this is not observable.
- No write-after-write hazards exist: there is one write port, and the last write wins per cycle.
- The array has no reset of its own; only the FSM and counter are asynchronously reset.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- When defined, the block adds these ports:
  - rsv_en  in  1.
  - rsv_bank  in  BW.
  - rsv_addr  in  AW.
  - rd_pending  out  NUM_READ  one bit per read port.
- The block keeps one pending bit per entry:
  - All pending bits are cleared during CLEAR.
  - In READY, rsv_en sets the pending bit of the addressed entry on posedge. Reserving x0 in bank 0 or an invalid bank is ignored.
  - A qualifying write clears the pending bit of the written entry.
  - If a reserve and a write hit the same entry on the same cycle, the reserve wins and the bit stays set.
- rd_pending[i] is 1 when the entry addressed by port i is pending and is not being bypassed this cycle. It is always 0 for bank-0 x0 and during CLEAR.
- When the macro is not defined, none of these ports or storage exist, and behaviour is otherwise identical.

Test Plan:
- Release rst_n and count cycles -> ready rises exactly 32 posedges later. Reads of any address during CLEAR -> 0. A wr_en of bank0/x5=0xFF during CLEAR is not stored: a read after ready returns 0.
- In READY, write bank0/x7=0xDEADBEEF_00000001, then read x7 on both ports the next cycle -> both return 0xDEADBEEF_00000001. Bank1/f7 -> 0.
- Write bank0/x0=0x1234 -> reading x0 returns 0 on the same cycle and all later cycles. Write bank1/f0=0x1234 -> reads 0x1234 on the next cycle.
- Present wr_en to bank1/f3=0xAA while port0 reads f3, which previously held 0x55 -> rd_data port0=0xAA in the same cycle, and f3=0xAA afterwards.
- Write x9=0x77, then pulse rst_n low for half a cycle -> ready drops immediately, reads return 0, ready returns 32 cycles after release, and x9 reads 0.
- With REGFILE_SCOREBOARD_EN: reserve bank0/x4 -> rd_pending=1 the next cycle. Reserve and write x4 on the same cycle -> pending stays 1. A later write of x4 alone -> pending=0.
